// File: rtl/ag32gbd_pkg.sv
// Shared constants, state encoding and helpers for the camera config RAM arbiter.
package ag32gbd_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam logic [DEF_ADDR_W-1:0] DEF_LOCK_BASE = 10'h200;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_DATA = 2'd3
  } arb_state_t;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                     input logic [STREAK_W-1:0] lim);
    return (cur >= lim) ? lim : cur + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/ag32gbd_bram_arb.sv
// Single-port config RAM arbiter: cart-side writer vs capture-engine reader,
// with table-region write deferral during capture and a bounded read streak.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | arbitrate between read and eligible write
// ST_WR      | write strobe on the RAM for one cycle, Wr_Done pulses
// ST_RD_ADDR | read address presented to the RAM
// ST_RD_DATA | RAM data returns, captured into Rd_Data with Rd_Valid
module ag32gbd_bram_arb
  import ag32gbd_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] LOCK_BASE    = ADDR_W'(DEF_LOCK_BASE),
  parameter int                STARVE_LIMIT = 4
) (
  input  logic              sys_clock,
  input  logic              sys_resetn,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Done,
  output logic              Wr_Stalled,
  input  logic              Rd_Req,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic              Rd_Valid,
  output logic [DATA_W-1:0] Rd_Data,
  input  logic              Cam_Busy,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_WData,
  input  logic [DATA_W-1:0] Ram_RData
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  arb_state_t          r_state,      w_state_nxt;
  logic [STREAK_W-1:0] r_streak,     w_streak_nxt;
  logic                r_ram_we,     w_ram_we_nxt;
  logic [ADDR_W-1:0]   r_ram_addr,   w_ram_addr_nxt;
  logic [DATA_W-1:0]   r_ram_wdata,  w_ram_wdata_nxt;
  logic                r_wr_done,    w_wr_done_nxt;
  logic                r_wr_stalled, w_wr_stalled_nxt;
  logic                r_rd_valid,   w_rd_valid_nxt;
  logic [DATA_W-1:0]   r_rd_data,    w_rd_data_nxt;

  logic w_wr_elig;
  logic w_rd_win;

  // Only the protected table region is held off while a capture runs.
  assign w_wr_elig = Wr_Req && !(Cam_Busy && (Wr_Addr >= LOCK_BASE));
  assign w_rd_win  = Rd_Req && (!w_wr_elig || (r_streak < LIMIT));

  always_comb begin
    w_state_nxt      = r_state;
    w_streak_nxt     = r_streak;
    w_ram_we_nxt     = 1'b0;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_wdata_nxt  = r_ram_wdata;
    w_wr_done_nxt    = 1'b0;
    w_wr_stalled_nxt = Wr_Req && !w_wr_elig;
    w_rd_valid_nxt   = 1'b0;
    w_rd_data_nxt    = r_rd_data;

    case (r_state)
      ST_IDLE: begin
        if (w_rd_win) begin
          w_state_nxt    = ST_RD_ADDR;
          w_ram_addr_nxt = Rd_Addr;
          w_streak_nxt   = w_wr_elig ? streak_inc(r_streak, LIMIT) : '0;
        end else if (w_wr_elig) begin
          w_state_nxt     = ST_WR;
          w_ram_we_nxt    = 1'b1;
          w_ram_addr_nxt  = Wr_Addr;
          w_ram_wdata_nxt = Wr_Data;
          w_wr_done_nxt   = 1'b1;
          w_streak_nxt    = '0;
        end else begin
          w_streak_nxt = '0;
        end
      end
      ST_WR: begin
        w_state_nxt = ST_IDLE;
      end
      ST_RD_ADDR: begin
        w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        w_state_nxt    = ST_IDLE;
        w_rd_valid_nxt = 1'b1;
        w_rd_data_nxt  = Ram_RData;
      end
    endcase
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state      <= ST_IDLE;
      r_streak     <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_wr_done    <= 1'b0;
      r_wr_stalled <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_streak     <= w_streak_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_wdata  <= w_ram_wdata_nxt;
      r_wr_done    <= w_wr_done_nxt;
      r_wr_stalled <= w_wr_stalled_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_rd_data    <= w_rd_data_nxt;
    end
  end

  assign Ram_We     = r_ram_we;
  assign Ram_Addr   = r_ram_addr;
  assign Ram_WData  = r_ram_wdata;
  assign Wr_Done    = r_wr_done;
  assign Wr_Stalled = r_wr_stalled;
  assign Rd_Valid   = r_rd_valid;
  assign Rd_Data    = r_rd_data;

endmodule

// File: tb/tb_ag32gbd_bram_arb.sv
// Bench for ag32gbd_bram_arb: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_ag32gbd_bram_arb;

  localparam int LIMIT = 4;

  logic       sys_clock = 1'b0;
  logic       sys_resetn = 1'b0;
  logic       Wr_Req = 1'b0;
  logic [9:0] Wr_Addr = '0;
  logic [7:0] Wr_Data = '0;
  logic       Wr_Done, Wr_Stalled;
  logic       Rd_Req = 1'b0;
  logic [9:0] Rd_Addr = '0;
  logic       Rd_Valid;
  logic [7:0] Rd_Data;
  logic       Cam_Busy = 1'b0;
  logic       Ram_We;
  logic [9:0] Ram_Addr;
  logic [7:0] Ram_WData;
  logic [7:0] Ram_RData = '0;

  ag32gbd_bram_arb #(.ADDR_W(10), .DATA_W(8), .LOCK_BASE(10'h200), .STARVE_LIMIT(LIMIT)) dut (
    .sys_clock(sys_clock), .sys_resetn(sys_resetn),
    .Wr_Req(Wr_Req), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Wr_Done(Wr_Done), .Wr_Stalled(Wr_Stalled),
    .Rd_Req(Rd_Req), .Rd_Addr(Rd_Addr), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
    .Cam_Busy(Cam_Busy), .Ram_We(Ram_We), .Ram_Addr(Ram_Addr), .Ram_WData(Ram_WData), .Ram_RData(Ram_RData)
  );

  always #5 sys_clock = ~sys_clock;

  // Physical RAM driven by the DUT, and the model's own copy of the contents.
  logic [7:0] mem   [1024];
  logic [7:0] m_mem [1024];

  always @(posedge sys_clock) begin
    if (Ram_We) mem[Ram_Addr] <= Ram_WData;
    Ram_RData <= mem[Ram_Addr];
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_we = 0, n_done = 0, n_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: the arbiter is either looking at requests or busy for a
  // known number of edges after a grant; reads deliver model-memory data.
  int         m_wait = 0;
  bit         m_rd_inflight = 1'b0;
  logic [7:0] m_rd_val = '0;
  int         m_streak = 0;
  bit         m_elig;
  logic       e_we = 0, e_done = 0, e_valid = 0, e_stalled = 0;
  logic [9:0] e_addr = '0;
  logic [7:0] e_wdata = '0, e_rdata = '0;

  always @(posedge sys_clock) begin
    if (!sys_resetn) begin
      m_wait = 0; m_rd_inflight = 0; m_streak = 0;
      e_we = 0; e_done = 0; e_valid = 0; e_stalled = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      m_elig = Wr_Req && !(Cam_Busy && (Wr_Addr >= 10'h200));
      e_we = 0; e_done = 0; e_valid = 0;
      e_stalled = Wr_Req && !m_elig;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0 && m_rd_inflight) begin
          e_valid = 1; e_rdata = m_rd_val; m_rd_inflight = 0;
        end
      end else if (Rd_Req && (!m_elig || m_streak < LIMIT)) begin
        m_wait = 2; m_rd_inflight = 1; m_rd_val = m_mem[Rd_Addr]; e_addr = Rd_Addr;
        m_streak = m_elig ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
      end else if (m_elig) begin
        m_wait = 1; e_we = 1; e_done = 1; e_addr = Wr_Addr; e_wdata = Wr_Data;
        m_mem[Wr_Addr] = Wr_Data; m_streak = 0;
      end else begin
        m_streak = 0;
      end
    end
  end

  always begin
    @(posedge sys_clock); #1;
    if (Ram_We) n_we++;
    if (Wr_Done) n_done++;
    if (Rd_Valid) n_valid++;
    if (sys_resetn && chk_en) begin
      check("cyc_ram_we", Ram_We, e_we);
      check("cyc_ram_addr", Ram_Addr, e_addr);
      check("cyc_ram_wdata", Ram_WData, e_wdata);
      check("cyc_wr_done", Wr_Done, e_done);
      check("cyc_wr_stalled", Wr_Stalled, e_stalled);
      check("cyc_rd_valid", Rd_Valid, e_valid);
      check("cyc_rd_data", Rd_Data, e_rdata);
    end
  end

  task automatic write_op(input logic [9:0] a, input logic [7:0] d, output int cyc,
                          output logic [9:0] s_addr, output logic [7:0] s_wdata, output logic s_we);
    @(negedge sys_clock);
    Wr_Req = 1'b1; Wr_Addr = a; Wr_Data = d;
    cyc = 0; s_addr = '0; s_wdata = '0; s_we = 1'b0;
    while (cyc < 10) begin
      @(posedge sys_clock); #2; cyc++;
      if (Wr_Done) break;
    end
    if (!Wr_Done) cyc = -1;
    else begin s_addr = Ram_Addr; s_wdata = Ram_WData; s_we = Ram_We; end
    @(negedge sys_clock);
    Wr_Req = 1'b0;
  endtask

  task automatic read_op(input logic [9:0] a, output int cyc, output logic [7:0] data);
    @(negedge sys_clock);
    Rd_Req = 1'b1; Rd_Addr = a; cyc = 0; data = '0;
    while (cyc < 10) begin
      @(posedge sys_clock); #2; cyc++;
      if (Rd_Valid) break;
    end
    if (!Rd_Valid) cyc = -1;
    else data = Rd_Data;
    @(negedge sys_clock);
    Rd_Req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_we"}, Ram_We, 0);
    check({tag, "_ram_addr"}, Ram_Addr, 0);
    check({tag, "_ram_wdata"}, Ram_WData, 0);
    check({tag, "_wr_done"}, Wr_Done, 0);
    check({tag, "_wr_stalled"}, Wr_Stalled, 0);
    check({tag, "_rd_valid"}, Rd_Valid, 0);
    check({tag, "_rd_data"}, Rd_Data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, base, nstall, c;
    logic [9:0] s_addr;
    logic [7:0] s_wdata, s_data;
    logic s_we;
    bit stop;
    int ev[$];
    int exp_ev[7];

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'(i * 37 + 5);
      m_mem[i] = mem[i];
    end
    mem[10'h230] = 8'hC3; m_mem[10'h230] = 8'hC3;

    repeat (3) @(posedge sys_clock);
    #2 check_all_zero("reset");
    @(negedge sys_clock);
    sys_resetn = 1'b1;
    chk_en = 1'b1;

    // Single write
    write_op(10'h200, 8'h5A, cyc, s_addr, s_wdata, s_we);
    check("wr_latency", cyc, 1);
    check("wr_ram_we", s_we, 1);
    check("wr_ram_addr", s_addr, 10'h200);
    check("wr_ram_wdata", s_wdata, 8'h5A);
    base = n_we;
    repeat (6) @(posedge sys_clock);
    #2 check("wr_no_extra_we", n_we - base, 0);

    // Single read
    read_op(10'h230, cyc, s_data);
    check("rd_latency", cyc, 3);
    check("rd_data", s_data, 8'hC3);

    // Region lock
    @(negedge sys_clock); Cam_Busy = 1'b1;
    write_op(10'h010, 8'h3C, cyc, s_addr, s_wdata, s_we);
    check("lock_low_wr_latency", cyc, 1);
    check("lock_low_wr_addr", s_addr, 10'h010);
    @(negedge sys_clock);
    Wr_Req = 1'b1; Wr_Addr = 10'h210; Wr_Data = 8'h77;
    base = n_we; nstall = 0;
    repeat (20) begin
      @(posedge sys_clock); #2;
      if (Wr_Stalled) nstall++;
    end
    check("lock_stalled_cycles", nstall, 20);
    check("lock_no_we", n_we - base, 0);
    @(negedge sys_clock); Cam_Busy = 1'b0;
    cyc = 0;
    while (cyc < 6) begin
      @(posedge sys_clock); #2; cyc++;
      if (Wr_Done) break;
    end
    check("lock_release_done", Wr_Done, 1);
    check("lock_release_within2", cyc <= 2, 1);
    check("lock_release_addr", Ram_Addr, 10'h210);
    check("lock_release_wdata", Ram_WData, 8'h77);
    @(negedge sys_clock);
    check("lock_release_unstalled", Wr_Stalled, 0);
    Wr_Req = 1'b0;
    repeat (3) @(negedge sys_clock);

    // Starvation bound: 4 reads, 1 write, then reads resume
    exp_ev = '{1, 1, 1, 1, 2, 1, 1};
    base = n_done; stop = 0; ev.delete();
    Rd_Req = 1'b1; Rd_Addr = 10'h230; Wr_Req = 1'b1; Wr_Addr = 10'h240; Wr_Data = 8'h99;
    c = 0;
    while (c < 40 && !stop) begin
      @(posedge sys_clock); #2;
      if (Rd_Valid) ev.push_back(1);
      if (Wr_Done) ev.push_back(2);
      @(negedge sys_clock);
      if (Wr_Done) Wr_Req = 1'b0;
      if (Rd_Valid && ev.size() >= 7) begin Rd_Req = 1'b0; stop = 1; end
      c++;
    end
    Rd_Req = 1'b0; Wr_Req = 1'b0;
    check("starve_event_count", ev.size() >= 7, 1);
    for (int i = 0; i < 7; i++)
      check($sformatf("starve_event_%0d", i), (i < ev.size()) ? ev[i] : 0, exp_ev[i]);
    check("starve_done_once", n_done - base, 1);
    repeat (4) @(negedge sys_clock);

    // Reset in RD_DATA
    @(negedge sys_clock); Rd_Req = 1'b1; Rd_Addr = 10'h230;
    @(posedge sys_clock); @(posedge sys_clock);
    #2 Rd_Req = 1'b0; sys_resetn = 1'b0;
    #1 check_all_zero("midrd_reset");
    @(posedge sys_clock); @(negedge sys_clock);
    sys_resetn = 1'b1;
    base = n_valid;
    repeat (6) @(posedge sys_clock);
    #2 check("midrd_no_valid", n_valid - base, 0);
    write_op(10'h020, 8'hA5, cyc, s_addr, s_wdata, s_we);
    check("midrd_idle_wr_latency", cyc, 1);

    // Read-after-write
    write_op(10'h205, 8'h11, cyc, s_addr, s_wdata, s_we);
    check("raw_wr_latency", cyc, 1);
    read_op(10'h205, cyc, s_data);
    check("raw_rd_latency", cyc, 3);
    check("raw_rd_data", s_data, 8'h11);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clock);
      if (Wr_Done) Wr_Req = 1'b0;
      else if (!Wr_Req && $urandom_range(0, 3) == 0) begin
        Wr_Req = 1'b1;
        Wr_Addr = ($urandom_range(0, 1) == 1) ? (10'h200 + 10'($urandom_range(0, 15)))
                                              : 10'($urandom_range(0, 15));
        Wr_Data = 8'($urandom);
      end
      if (Rd_Valid) begin
        if ($urandom_range(0, 1) == 1) Rd_Req = 1'b0;
        else Rd_Addr = 10'h200 + 10'($urandom_range(0, 15));
      end else if (!Rd_Req && $urandom_range(0, 2) == 0) begin
        Rd_Req = 1'b1;
        Rd_Addr = ($urandom_range(0, 1) == 1) ? (10'h200 + 10'($urandom_range(0, 15)))
                                              : 10'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) Cam_Busy = ~Cam_Busy;
    end

    Cam_Busy = 1'b0;
    c = 0;
    while ((Wr_Req || Rd_Req) && c < 40) begin
      @(negedge sys_clock);
      if (Wr_Done) Wr_Req = 1'b0;
      if (Rd_Valid) Rd_Req = 1'b0;
      c++;
    end
    check("drain_requests_idle", {Wr_Req, Rd_Req}, 0);
    repeat (5) @(posedge sys_clock);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
